// File: rtl/executs_mdu_pkg.sv
// exe_pkg: shared decode constants and encodings for executs_mdu.
//   - funct / opcode values the execute stage recognises
//   - ALUOp encodings from the decoder
//   - MDU FSM states and MDU operation codes
//   - internal ALU control encoding
package exe_pkg;

    // ALUOp from the decoder
    localparam logic [1:0] ALUOP_ADDR   = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_ARITH  = 2'b10;

    // R-type funct values
    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_SRL   = 6'b000010;
    localparam logic [5:0] F_SRA   = 6'b000011;
    localparam logic [5:0] F_SLLV  = 6'b000100;
    localparam logic [5:0] F_SRLV  = 6'b000110;
    localparam logic [5:0] F_SRAV  = 6'b000111;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_ADDU  = 6'b100001;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_SUBU  = 6'b100011;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_XOR   = 6'b100110;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLTU  = 6'b101011;

    // I-type opcodes
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;

    typedef enum logic [1:0] {IDLE, ITER, FIX} mdu_state_t;

    // Matches funct[1:0] of mult/multu/div/divu: bit 0 = unsigned, bit 1 = divide
    typedef enum logic [1:0] {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU} md_op_t;

    typedef enum logic [3:0] {
        ALU_ZERO, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
        ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI, ALU_HI, ALU_LO
    } alu_ctl_t;

endpackage

// File: rtl/mdu_iter.sv
// mdu_iter: iterative multiply / divide, one result bit per clock.
//   clock, reset      clock and asynchronous active-low reset
//   i_start           begin an operation (only honoured in IDLE)
//   i_op              md_op_t code (mult, multu, div, divu)
//   i_a, i_b          rs / rt operands
//   i_flush           abandon the operation, return to IDLE, no write
//   o_busy            FSM not in IDLE
//   o_wr              HI/LO write strobe (FIX state, not flushed)
//   o_hi, o_lo        signed-corrected results, valid while o_wr is high
//   o_done            one-cycle pulse the cycle after the write
module mdu_iter
    import exe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            i_start,
    input  logic [1:0]      i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    input  logic            i_flush,
    output logic            o_busy,
    output logic            o_wr,
    output logic [XLEN-1:0] o_hi,
    output logic [XLEN-1:0] o_lo,
    output logic            o_done
);
    localparam int CW = $clog2(XLEN) + 1;

    mdu_state_t      r_state, w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [XLEN-1:0] r_acc;     // product high half / partial remainder
    logic [XLEN-1:0] r_q;       // multiplier then product low half / dividend then quotient
    logic [XLEN-1:0] r_m;       // multiplicand / divisor magnitude
    logic            r_is_div, r_neg_res, r_neg_a, r_done;

    logic            w_signed, w_a_neg, w_b_neg;
    logic [XLEN-1:0] w_a_mag, w_b_mag, w_addend, w_quo, w_rem;
    logic [XLEN:0]   w_sum, w_shift, w_diff;
    logic [2*XLEN-1:0] w_prod;

    // Signed ops work on magnitudes; signs are reapplied in FIX
    assign w_signed = ~i_op[0];
    assign w_a_neg  = w_signed & i_a[XLEN-1];
    assign w_b_neg  = w_signed & i_b[XLEN-1];
    assign w_a_mag  = w_a_neg ? -i_a : i_a;
    assign w_b_mag  = w_b_neg ? -i_b : i_b;

    // Shift-add multiply step
    assign w_addend = r_q[0] ? r_m : '0;
    assign w_sum    = {1'b0, r_acc} + {1'b0, w_addend};
    // Restoring divide step: a non-negative difference means the divisor fits
    assign w_shift  = {r_acc, r_q[XLEN-1]};
    assign w_diff   = w_shift - {1'b0, r_m};

    assign w_prod = r_neg_res ? -{r_acc, r_q} : {r_acc, r_q};
    assign w_quo  = r_neg_res ? -r_q : r_q;
    assign w_rem  = r_neg_a ? -r_acc : r_acc;

    // A zero divisor leaves quotient all ones and remainder |a|; the remainder
    // sign fix restores the dividend, but LO must stay all ones unconditionally.
    assign o_hi   = r_is_div ? w_rem : w_prod[2*XLEN-1:XLEN];
    assign o_lo   = r_is_div ? ((r_m == '0) ? '1 : w_quo) : w_prod[XLEN-1:0];
    assign o_wr   = (r_state == FIX) && !i_flush;
    assign o_busy = (r_state != IDLE);
    assign o_done = r_done;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (i_start) w_state_nxt = ITER;
            ITER:    if (r_cnt == CW'(1)) w_state_nxt = FIX;
            FIX:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        if (i_flush) w_state_nxt = IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_q       <= '0;
            r_m       <= '0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_a   <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= o_wr;
            if (r_state == IDLE && i_start) begin
                r_cnt     <= CW'(XLEN);
                r_acc     <= '0;
                r_q       <= w_a_mag;
                r_m       <= w_b_mag;
                r_is_div  <= i_op[1];
                r_neg_res <= w_a_neg ^ w_b_neg;
                r_neg_a   <= w_a_neg;
            end else if (r_state == ITER) begin
                r_cnt <= r_cnt - CW'(1);
                if (r_is_div) begin
                    if (!w_diff[XLEN]) begin
                        r_acc <= w_diff[XLEN-1:0];
                        r_q   <= {r_q[XLEN-2:0], 1'b1};
                    end else begin
                        r_acc <= w_shift[XLEN-1:0];
                        r_q   <= {r_q[XLEN-2:0], 1'b0};
                    end
                end else begin
                    r_acc <= w_sum[XLEN:1];
                    r_q   <= {w_sum[0], r_q[XLEN-1:1]};
                end
            end
        end
    end

endmodule

// File: rtl/executs_mdu.sv
// executs_mdu: registered Minisys execute stage with iterative MDU.
//   clock, reset             clock and asynchronous active-low reset
//   in_valid / in_ready      issue handshake; in_ready low while the MDU is busy
//   flush                    abort MDU op and suppress this cycle's issue
//   Read_data_1/2            rs / rt values
//   Sign_extend, Shamt       immediate and shift amount
//   Function_opcode, Exe_opcode, ALUOp, Sftmd, ALUSrc, I_format   decode controls
//   PC_plus_4                branch base
//   out_valid, ALU_Result, Zero, Add_Result   registered results (latency 1)
//   md_done, hi, lo          MDU completion pulse and architectural HI/LO
module executs_mdu
    import exe_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            flush,
    input  logic [XLEN-1:0] Read_data_1,
    input  logic [XLEN-1:0] Read_data_2,
    input  logic [XLEN-1:0] Sign_extend,
    input  logic [5:0]      Function_opcode,
    input  logic [5:0]      Exe_opcode,
    input  logic [1:0]      ALUOp,
    input  logic [SHW-1:0]  Shamt,
    input  logic            Sftmd,
    input  logic            ALUSrc,
    input  logic            I_format,
    input  logic [XLEN-1:0] PC_plus_4,
    output logic            out_valid,
    output logic [XLEN-1:0] ALU_Result,
    output logic            Zero,
    output logic [XLEN-1:0] Add_Result,
    output logic            md_done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);
    localparam int LUI_SH = (XLEN >= 32) ? 16 : XLEN / 2;

    alu_ctl_t        w_ctl;
    logic            w_var_sh, w_md_start, w_mthi, w_mtlo, w_accept, w_writes;
    logic [XLEN-1:0] w_b, w_res;
    logic [SHW-1:0]  w_shamt;
    logic            w_md_busy, w_md_wr, w_md_done;
    logic [XLEN-1:0] w_md_hi, w_md_lo;

    logic            r_out_valid, r_zero;
    logic [XLEN-1:0] r_result, r_add, r_hi, r_lo;

    always_comb begin
        w_ctl      = ALU_ZERO;
        w_var_sh   = 1'b0;
        w_md_start = 1'b0;
        w_mthi     = 1'b0;
        w_mtlo     = 1'b0;
        case (ALUOp)
            ALUOP_ADDR:   w_ctl = ALU_ADD;
            ALUOP_BRANCH: w_ctl = ALU_SUB;
            ALUOP_ARITH: begin
                if (I_format) begin
                    case (Exe_opcode)
                        OP_ADDI, OP_ADDIU: w_ctl = ALU_ADD;
                        OP_SLTI:           w_ctl = ALU_SLT;
                        OP_SLTIU:          w_ctl = ALU_SLTU;
                        OP_ANDI:           w_ctl = ALU_AND;
                        OP_ORI:            w_ctl = ALU_OR;
                        OP_XORI:           w_ctl = ALU_XOR;
                        OP_LUI:            w_ctl = ALU_LUI;
                        default:           w_ctl = ALU_ZERO;
                    endcase
                end else if (Sftmd) begin
                    w_var_sh = Function_opcode[2];
                    case (Function_opcode)
                        F_SLL, F_SLLV: w_ctl = ALU_SLL;
                        F_SRL, F_SRLV: w_ctl = ALU_SRL;
                        F_SRA, F_SRAV: w_ctl = ALU_SRA;
                        default:       w_ctl = ALU_ZERO;
                    endcase
                end else begin
                    case (Function_opcode)
                        F_ADD, F_ADDU: w_ctl = ALU_ADD;
                        F_SUB, F_SUBU: w_ctl = ALU_SUB;
                        F_AND:         w_ctl = ALU_AND;
                        F_OR:          w_ctl = ALU_OR;
                        F_XOR:         w_ctl = ALU_XOR;
                        F_NOR:         w_ctl = ALU_NOR;
                        F_SLT:         w_ctl = ALU_SLT;
                        F_SLTU:        w_ctl = ALU_SLTU;
                        F_MFHI:        w_ctl = ALU_HI;
                        F_MFLO:        w_ctl = ALU_LO;
                        F_MTHI:        w_mthi = 1'b1;
                        F_MTLO:        w_mtlo = 1'b1;
                        F_MULT, F_MULTU, F_DIV, F_DIVU: w_md_start = 1'b1;
                        default:       w_ctl = ALU_ZERO;
                    endcase
                end
            end
            default: w_ctl = ALU_ZERO;
        endcase
    end

    assign w_b      = ALUSrc ? Sign_extend : Read_data_2;
    assign w_shamt  = w_var_sh ? Read_data_1[SHW-1:0] : Shamt;
    assign in_ready = !w_md_busy;
    // flush outranks an issue in the same cycle
    assign w_accept = in_valid && in_ready && !flush;
    assign w_writes = !(w_mthi || w_mtlo || w_md_start);

    always_comb begin
        w_res = '0;
        case (w_ctl)
            ALU_ADD:  w_res = Read_data_1 + w_b;
            ALU_SUB:  w_res = Read_data_1 - w_b;
            ALU_AND:  w_res = Read_data_1 & w_b;
            ALU_OR:   w_res = Read_data_1 | w_b;
            ALU_XOR:  w_res = Read_data_1 ^ w_b;
            ALU_NOR:  w_res = ~(Read_data_1 | w_b);
            ALU_SLT:  w_res[0] = $signed(Read_data_1) < $signed(w_b);
            ALU_SLTU: w_res[0] = Read_data_1 < w_b;
            ALU_SLL:  w_res = Read_data_2 << w_shamt;
            ALU_SRL:  w_res = Read_data_2 >> w_shamt;
            ALU_SRA:  w_res = $signed(Read_data_2) >>> w_shamt;
            ALU_LUI:  w_res = Sign_extend << LUI_SH;
            ALU_HI:   w_res = r_hi;
            ALU_LO:   w_res = r_lo;
            default:  w_res = '0;
        endcase
    end

    mdu_iter #(.XLEN(XLEN)) u_mdu (
        .clock   (clock),
        .reset   (reset),
        .i_start (w_accept && w_md_start),
        .i_op    (Function_opcode[1:0]),
        .i_a     (Read_data_1),
        .i_b     (Read_data_2),
        .i_flush (flush),
        .o_busy  (w_md_busy),
        .o_wr    (w_md_wr),
        .o_hi    (w_md_hi),
        .o_lo    (w_md_lo),
        .o_done  (w_md_done)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_add       <= '0;
            r_hi        <= '0;
            r_lo        <= '0;
        end else begin
            r_out_valid <= w_accept && w_writes;
            if (w_accept && w_writes) begin
                r_result <= w_res;
                r_zero   <= (w_res == '0);
            end
            if (w_accept) r_add <= PC_plus_4 + (Sign_extend << 2);
            // MDU writes and mthi/mtlo never coincide: issue is blocked while busy
            if (w_md_wr) begin
                r_hi <= w_md_hi;
                r_lo <= w_md_lo;
            end else begin
                if (w_accept && w_mthi) r_hi <= Read_data_1;
                if (w_accept && w_mtlo) r_lo <= Read_data_1;
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign ALU_Result = r_result;
    assign Zero       = r_zero;
    assign Add_Result = r_add;
    assign md_done    = w_md_done;
    assign hi         = r_hi;
    assign lo         = r_lo;

endmodule

// File: tb/tb_executs_mdu.sv
module tb_executs_mdu;
    localparam int XLEN = 32;
    localparam int SHW  = 5;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            in_valid = 1'b0, flush = 1'b0;
    logic            in_ready;
    logic [XLEN-1:0] Read_data_1 = '0, Read_data_2 = '0, Sign_extend = '0, PC_plus_4 = '0;
    logic [5:0]      Function_opcode = '0, Exe_opcode = '0;
    logic [1:0]      ALUOp = '0;
    logic [SHW-1:0]  Shamt = '0;
    logic            Sftmd = 1'b0, ALUSrc = 1'b0, I_format = 1'b0;
    logic            out_valid, Zero, md_done;
    logic [XLEN-1:0] ALU_Result, Add_Result, hi, lo;

    always #5 clock = ~clock;

    executs_mdu #(.XLEN(XLEN), .SHW(SHW)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .Read_data_1(Read_data_1), .Read_data_2(Read_data_2), .Sign_extend(Sign_extend),
        .Function_opcode(Function_opcode), .Exe_opcode(Exe_opcode), .ALUOp(ALUOp),
        .Shamt(Shamt), .Sftmd(Sftmd), .ALUSrc(ALUSrc), .I_format(I_format),
        .PC_plus_4(PC_plus_4), .out_valid(out_valid), .ALU_Result(ALU_Result), .Zero(Zero),
        .Add_Result(Add_Result), .md_done(md_done), .hi(hi), .lo(lo)
    );

    typedef struct {
        logic [31:0] res;
        logic        zero;
        logic        chk_add;
        logic [31:0] add;
        string       tag;
    } alu_exp_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        string       tag;
    } md_exp_t;

    alu_exp_t alu_q[$];
    md_exp_t  md_q[$];
    int n_pass = 0, n_fail = 0, n_total = 0, md_count = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: pop expectations as the DUT produces results
    always @(negedge clock) begin
        alu_exp_t ea;
        md_exp_t  em;
        if (reset) begin
            if (out_valid) begin
                check("alu_result_expected", alu_q.size() != 0, 1'b1);
                if (alu_q.size() != 0) begin
                    ea = alu_q.pop_front();
                    check({ea.tag, "_res"}, ALU_Result, ea.res);
                    check({ea.tag, "_zero"}, Zero, ea.zero);
                    if (ea.chk_add) check({ea.tag, "_add"}, Add_Result, ea.add);
                end
            end
            if (md_done) begin
                md_count++;
                check("md_result_expected", md_q.size() != 0, 1'b1);
                if (md_q.size() != 0) begin
                    em = md_q.pop_front();
                    check({em.tag, "_hi"}, hi, em.hi);
                    check({em.tag, "_lo"}, lo, em.lo);
                end
            end
        end
    end

    // Drives one instruction from a negedge, holds it until accepted, returns at the
    // negedge after the accept edge with the number of stalled cycles.
    task automatic send(input string tag, input logic [1:0] aluop, input logic ifmt,
                        input logic [5:0] opc, input logic [5:0] fn, input logic [31:0] rs,
                        input logic [31:0] rt, input logic [31:0] imm, input logic alusrc,
                        input logic sft, input logic [4:0] sh, input logic [31:0] pc,
                        input logic push, input logic [31:0] exp, input logic chk_add,
                        input logic [31:0] exp_add, output int stalls);
        alu_exp_t e;
        ALUOp = aluop; I_format = ifmt; Exe_opcode = opc; Function_opcode = fn;
        Read_data_1 = rs; Read_data_2 = rt; Sign_extend = imm; ALUSrc = alusrc;
        Sftmd = sft; Shamt = sh; PC_plus_4 = pc; in_valid = 1'b1;
        if (push) begin
            e.res = exp; e.zero = (exp == 32'h0); e.chk_add = chk_add; e.add = exp_add; e.tag = tag;
            alu_q.push_back(e);
        end
        stalls = 0;
        while (!in_ready && stalls < 200) begin
            @(negedge clock);
            stalls++;
        end
        if (!in_ready) check({tag, "_accept_timeout"}, in_ready, 1'b1);
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic rop(input string tag, input logic [5:0] fn, input logic [31:0] rs,
                       input logic [31:0] rt, input logic [4:0] sh, input logic sft,
                       input logic push, input logic [31:0] exp, output int stalls);
        send(tag, 2'b10, 1'b0, 6'h00, fn, rs, rt, 32'h0, 1'b0, sft, sh, 32'h0,
             push, exp, 1'b0, 32'h0, stalls);
    endtask

    task automatic iop(input string tag, input logic [5:0] opc, input logic [31:0] rs,
                       input logic [31:0] imm, input logic [31:0] exp);
        int st;
        send(tag, 2'b10, 1'b1, opc, 6'h00, rs, 32'h0, imm, 1'b1, 1'b0, 5'd0, 32'h0,
             1'b1, exp, 1'b0, 32'h0, st);
    endtask

    task automatic push_md(input string tag, input logic [31:0] h, input logic [31:0] l);
        md_exp_t e;
        e.hi = h; e.lo = l; e.tag = tag;
        md_q.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int st;
        int md_before;

        // Reset state
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_result", ALU_Result, 32'h0);
        check("rst_add", Add_Result, 32'h0);
        check("rst_md_done", md_done, 1'b0);
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);

        // ALU operations (latency 1, checked by the scoreboard)
        rop("add", 6'b100000, 32'd5, 32'd6, 5'd0, 1'b0, 1'b1, 32'h0000000B, st);
        rop("subu_eq", 6'b100011, 32'd5, 32'd5, 5'd0, 1'b0, 1'b1, 32'h0, st);
        send("beq", 2'b01, 1'b0, 6'b000100, 6'h00, 32'd1, 32'd1, 32'd4, 1'b0, 1'b0, 5'd0,
             32'h18, 1'b1, 32'h0, 1'b1, 32'h28, st);
        rop("slt", 6'b101010, 32'hFFFFFFFF, 32'd1, 5'd0, 1'b0, 1'b1, 32'h1, st);
        rop("sltu", 6'b101011, 32'hFFFFFFFF, 32'd1, 5'd0, 1'b0, 1'b1, 32'h0, st);
        rop("sll", 6'b000000, 32'h0, 32'h1, 5'd4, 1'b1, 1'b1, 32'h10, st);
        rop("sra", 6'b000011, 32'h0, 32'h80000000, 5'd3, 1'b1, 1'b1, 32'hF0000000, st);
        rop("srlv", 6'b000110, 32'd36, 32'h80, 5'd0, 1'b1, 1'b1, 32'h8, st);
        rop("srav", 6'b000111, 32'd1, 32'h80000000, 5'd0, 1'b1, 1'b1, 32'hC0000000, st);
        rop("nor", 6'b100111, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1, 32'hFFFFFFFF, st);
        rop("xor", 6'b100110, 32'hA5A5, 32'hFFFF, 5'd0, 1'b0, 1'b1, 32'h5A5A, st);
        iop("addi_wrap", 6'b001000, 32'hFFFFFFFF, 32'h1, 32'h0);
        iop("lui", 6'b001111, 32'h0, 32'h1234, 32'h12340000);
        send("lw_addr", 2'b00, 1'b0, 6'b100011, 6'h00, 32'h100, 32'h0, 32'h8, 1'b1, 1'b0,
             5'd0, 32'h0, 1'b1, 32'h108, 1'b0, 32'h0, st);
        rop("unknown", 6'b111111, 32'h12, 32'h34, 5'd0, 1'b0, 1'b1, 32'h0, st);

        // mthi/mtlo write at accept and produce no ALU result
        rop("mthi", 6'b010001, 32'h55, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0, st);
        check("mthi_hi", hi, 32'h55);
        rop("mtlo", 6'b010011, 32'h66, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0, st);
        check("mtlo_lo", lo, 32'h66);
        rop("mfhi", 6'b010000, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1, 32'h55, st);
        rop("mflo", 6'b010010, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1, 32'h66, st);

        // mult -2 * 3, with an mflo held across the busy window
        md_before = md_count;
        push_md("mult", 32'hFFFFFFFF, 32'hFFFFFFFA);
        rop("mult", 6'b011000, 32'hFFFFFFFE, 32'd3, 5'd0, 1'b0, 1'b0, 32'h0, st);
        check("mult_busy", in_ready, 1'b0);
        rop("mflo_after_mult", 6'b010010, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1, 32'hFFFFFFFA, st);
        check("mult_stall_cycles", st, 33);
        repeat (3) @(negedge clock);
        check("mult_done_pulses", md_count - md_before, 1);

        // Divides
        push_md("div_m7_2", 32'hFFFFFFFF, 32'hFFFFFFFD);
        rop("div", 6'b011010, 32'hFFFFFFF9, 32'd2, 5'd0, 1'b0, 1'b0, 32'h0, st);
        rop("mfhi_after_div", 6'b010000, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1, 32'hFFFFFFFF, st);
        push_md("divu_by0", 32'h7, 32'hFFFFFFFF);
        rop("divu0", 6'b011011, 32'd7, 32'd0, 5'd0, 1'b0, 1'b0, 32'h0, st);
        rop("mflo_after_div0", 6'b010010, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1, 32'hFFFFFFFF, st);
        push_md("div_min_m1", 32'h0, 32'h80000000);
        rop("divmin", 6'b011010, 32'h80000000, 32'hFFFFFFFF, 5'd0, 1'b0, 1'b0, 32'h0, st);
        rop("mflo_after_min", 6'b010010, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1, 32'h80000000, st);

        // flush together with in_valid: nothing accepted
        ALUOp = 2'b10; I_format = 1'b0; Sftmd = 1'b0; Function_opcode = 6'b100000;
        Read_data_1 = 32'd1; Read_data_2 = 32'd1; in_valid = 1'b1; flush = 1'b1;
        @(negedge clock);
        in_valid = 1'b0; flush = 1'b0;
        check("flush_issue_dropped", out_valid, 1'b0);

        // flush 10 cycles into a divu
        rop("mthi2", 6'b010001, 32'hAAAA, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0, st);
        rop("mtlo2", 6'b010011, 32'hBBBB, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0, st);
        md_before = md_count;
        rop("divu_flushed", 6'b011011, 32'd100, 32'd3, 5'd0, 1'b0, 1'b0, 32'h0, st);
        repeat (9) @(negedge clock);
        check("divu_busy_before_flush", in_ready, 1'b0);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        check("flush_in_ready", in_ready, 1'b1);
        repeat (40) @(negedge clock);
        check("flush_no_done", md_count - md_before, 0);
        check("flush_hi_kept", hi, 32'hAAAA);
        check("flush_lo_kept", lo, 32'hBBBB);
        rop("mfhi_after_flush", 6'b010000, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1, 32'hAAAA, st);

        // Asynchronous reset in the middle of a mult
        md_before = md_count;
        rop("mult_reset", 6'b011001, 32'd9, 32'd9, 5'd0, 1'b0, 1'b0, 32'h0, st);
        repeat (5) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check("async_rst_hi", hi, 32'h0);
        check("async_rst_lo", lo, 32'h0);
        check("async_rst_out_valid", out_valid, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("post_rst_in_ready", in_ready, 1'b1);
        repeat (40) @(negedge clock);
        check("post_rst_no_done", md_count - md_before, 0);

        @(negedge clock);
        check("alu_queue_drained", alu_q.size(), 0);
        check("md_queue_drained", md_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
